// File: rtl/jzjcoref_fetch_pkg.sv
// Shared types for the instruction fetch unit.
//   FetchState : fetch FSM encoding (FETCH, FAULT)
//   PC_STEP    : PC increment per instruction word
//   FetchEntry : queued instruction word plus the PC it was fetched from
package jzjcoref_fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } FetchState;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } FetchEntry;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of FetchEntry between the memory response path and the
// decoder handshake.
//   clock, reset : clock, async active-high reset
//   push/push_data : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the queue; wins over push and pop
//   head         : oldest entry, all zero when empty
//   empty/full/count : occupancy status
module fetch_queue
  import jzjcoref_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  FetchEntry     push_data,
  input  logic          pop,
  input  logic          flush,
  output FetchEntry     head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  FetchEntry     mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage ahead of the decoder. Owns the fetch PC, issues word reads to
// instruction memory under a credit limit, buffers returned words with their
// PC and hands them to the decoder over valid/ready. Redirects flush the
// queue and discard every read still in flight; misaligned targets halt
// fetching until an aligned redirect arrives.
//   clock, reset                  : clock, async active-high reset
//   imem_req_valid/ready/addr     : read request channel
//   imem_rsp_valid/data           : in-order read data, no backpressure
//   redirect_valid/target         : branch/jump redirect from execute
//   instr_valid/ready, instruction, instr_pc : decoder handshake
//   fetch_fault                   : misaligned redirect seen, fetch halted
module instruction_fetch_unit
  import jzjcoref_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  FetchState     state_q;
  logic          fault_q;
  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;

  logic          q_push, q_pop, q_empty, q_full;
  logic [CW-1:0] q_count;
  FetchEntry     q_head, q_wdata;

  logic [CW:0]   inflight;
  logic          credit_ok, req_fire, rsp_acc, rsp_drop;

  // Reads in flight plus buffered words never exceed the queue size, so an
  // accepted response always has a free slot.
  assign inflight  = {1'b0, outst_q} + {1'b0, q_count};
  assign credit_ok = inflight < (CW+1)'(QUEUE_DEPTH);

  // run_q holds requests off for the first cycle after reset release.
  assign imem_req_valid = run_q && (state_q == FETCH) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_acc        = imem_rsp_valid && (disc_q == '0);
  assign rsp_drop       = imem_rsp_valid && (disc_q != '0);

  assign q_push  = rsp_acc && !redirect_valid;
  assign q_pop   = instr_valid && instr_ready;
  assign q_wdata = '{instruction: imem_rsp_data, pc: rsp_pc_q};

  assign instr_valid = !q_empty && !redirect_valid;
  assign instruction = q_head.instruction;
  assign instr_pc    = q_head.pc;
  assign fetch_fault = fault_q;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    if (redirect_valid) begin
      // A response landing this cycle is dropped here, so it is not
      // counted among the reads left to discard.
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      outst_d    = outst_q - CW'(imem_rsp_valid);
      disc_d     = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_acc)  rsp_pc_d   = rsp_pc_q + PC_STEP;
      if (rsp_drop) disc_d     = disc_q - CW'(1);
      outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: if (redirect_valid && misaligned(redirect_target)) begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end
        FAULT: if (redirect_valid && !misaligned(redirect_target)) begin
          state_q <= FETCH;
          fault_q <= 1'b0;
        end
        default: begin
          state_q <= FETCH;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assert property (@(posedge clock) disable iff (reset) !(q_push && q_full));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import jzjcoref_fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;
  logic        fetch_fault;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.RESET_VECTOR(RV), .QUEUE_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;

  int checks = 0, errors = 0, cyc = 0, n_req = 0, n_pop = 0;
  pend_t       pend[$];
  FetchEntry   exp_q[$];
  logic [31:0] model_pc;
  logic        model_fault;
  int          last_due, lat;
  bit          lat_rand;
  logic        rdy, irdy, rd_v;
  logic [31:0] rd_t;
  logic        prev_stall;
  logic [31:0] prev_addr, last_pop_pc, last_pop_ins;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One cycle: memory and stimulus driven after the falling edge, outputs
  // sampled 1ns later, scoreboard updated for the coming rising edge.
  task automatic step();
    int L, due;
    FetchEntry e;
    @(negedge clock);
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend[0].addr);
      pend.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    redirect_valid  = rd_v;
    redirect_target = rd_t;
    imem_req_ready  = rdy;
    instr_ready     = irdy;
    #1;
    checks++;
    if (fetch_fault !== model_fault) begin
      errors++; $display("FAIL fetch_fault cyc %0d got %0b exp %0b", cyc, fetch_fault, model_fault);
    end
    if (rd_v) begin
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL redirect_quiet cyc %0d req_valid %0b instr_valid %0b exp 0 0", cyc, imem_req_valid, instr_valid);
      end
      model_pc    = rd_t;
      model_fault = (rd_t[1:0] != 2'b00);
      exp_q.delete();
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
          errors++; $display("FAIL req_hold cyc %0d valid %0b addr %h exp 1 %h", cyc, imem_req_valid, imem_req_addr, prev_addr);
        end
      end
      if (model_fault) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++; $display("FAIL fault_req cyc %0d req_valid %0b exp 0", cyc, imem_req_valid);
        end
      end
      if (imem_req_valid === 1'b1) begin
        checks++;
        if (imem_req_addr !== model_pc) begin
          errors++; $display("FAIL req_addr cyc %0d got %h exp %h", cyc, imem_req_addr, model_pc);
        end
        if (rdy) begin
          n_req++;
          L   = lat_rand ? int'($urandom_range(5, 1)) : lat;
          due = cyc + L;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{imem_req_addr, due});
          exp_q.push_back('{instruction: word(model_pc), pc: model_pc});
          model_pc = model_pc + 32'd4;
        end
      end
      prev_stall = (imem_req_valid === 1'b1) && !rdy;
      prev_addr  = imem_req_addr;
      if (instr_valid === 1'b1 && irdy) begin
        n_pop++;
        last_pop_pc  = instr_pc;
        last_pop_ins = instruction;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_instr cyc %0d pc %h exp none", cyc, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e.pc || instruction !== e.instruction) begin
            errors++; $display("FAIL instr cyc %0d pc %h ins %h exp %h %h", cyc, instr_pc, instruction, e.pc, e.instruction);
          end
        end
      end
    end
    rd_v = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    rd_v = 1'b0; rd_t = '0;
    pend.delete(); exp_q.delete();
    model_pc = RV; model_fault = 1'b0; last_due = cyc; prev_stall = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0 ||
        instruction !== 32'h0 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL %s req_valid %0b instr_valid %0b fault %0b ins %h pc %h exp all 0",
               name, imem_req_valid, instr_valid, fetch_fault, instruction, instr_pc);
    end
  endtask

  task automatic drain();
    int k = 0;
    rdy = 1'b0; irdy = 1'b1;
    while ((exp_q.size() != 0 || pend.size() != 0) && k < 60) begin step(); k++; end
    checks++;
    if (exp_q.size() != 0 || pend.size() != 0) begin
      errors++; $display("FAIL drain_timeout exp_left %0d pend_left %0d exp 0 0", exp_q.size(), pend.size());
    end
    step();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty instr_valid %0b exp 0", instr_valid);
    end
  endtask

  task automatic wait_pop(input logic [31:0] exp_pc);
    int p = n_pop;
    int k = 0;
    while (n_pop == p && k < 30) begin step(); k++; end
    checks++;
    if (n_pop == p) begin
      errors++; $display("FAIL pop_timeout exp_pc %h got none", exp_pc);
    end else if (last_pop_pc !== exp_pc || last_pop_ins !== word(exp_pc)) begin
      errors++; $display("FAIL pop_pc got %h %h exp %h %h", last_pop_pc, last_pop_ins, exp_pc, word(exp_pc));
    end
  endtask

  task automatic test_reset();
    #2;
    check_zero_outputs("reset_outputs");
    do_reset();
    rdy = 1'b1; irdy = 1'b1; lat = 1; lat_rand = 0;
    check_zero_outputs("reset_release_cycle");
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RV) begin
      errors++; $display("FAIL first_req valid %0b addr %h exp 1 %h", imem_req_valid, imem_req_addr, RV);
    end
    drain();
  endtask

  task automatic test_basic();
    int p0, r0;
    do_reset();
    rdy = 1'b1; irdy = 1'b1; lat = 1; lat_rand = 0;
    p0 = n_pop; r0 = n_req;
    repeat (3) step();
    checks++;
    if (n_pop - p0 != 1) begin errors++; $display("FAIL first_instr_latency pops %0d exp 1", n_pop - p0); end
    step();
    checks++;
    if (n_pop - p0 != 2) begin errors++; $display("FAIL second_instr pops %0d exp 2", n_pop - p0); end
    repeat (20) step();
    drain();
    checks++;
    if (n_pop - p0 != n_req - r0) begin errors++; $display("FAIL basic_count pops %0d exp %0d", n_pop - p0, n_req - r0); end
  endtask

  task automatic test_stall();
    int r0;
    do_reset();
    rdy = 1'b1; irdy = 1'b0; lat = 1; lat_rand = 0;
    r0 = n_req;
    repeat (12) step();
    checks++;
    if (n_req - r0 != 2 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stall_credit reqs %0d req_valid %0b exp 2 0", n_req - r0, imem_req_valid);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RV) begin
      errors++; $display("FAIL stall_head valid %0b pc %h exp 1 %h", instr_valid, instr_pc, RV);
    end
    irdy = 1'b1;
    wait_pop(RV);
    wait_pop(RV + 32'h4);
    wait_pop(RV + 32'h8);
    drain();
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    rdy = 1'b1; irdy = 1'b1; lat = 5; lat_rand = 0;
    step(); step();
    rd_v = 1'b1; rd_t = 32'h100;
    step();
    wait_pop(32'h100);
    wait_pop(32'h104);
    drain();
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    rdy = 1'b1; irdy = 1'b0; lat = 1; lat_rand = 0;
    step(); step();
    rd_v = 1'b1; rd_t = 32'h200;
    step();
    irdy = 1'b1;
    step();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL flushed_empty instr_valid %0b exp 0", instr_valid); end
    wait_pop(32'h200);
    drain();
  endtask

  task automatic test_fault();
    int r0;
    do_reset();
    rdy = 1'b1; irdy = 1'b1; lat = 2; lat_rand = 0;
    repeat (6) step();
    rd_v = 1'b1; rd_t = 32'h102;
    step();
    r0 = n_req;
    repeat (6) step();
    checks++;
    if (fetch_fault !== 1'b1 || n_req != r0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL fault_halt fault %0b reqs %0d req_valid %0b exp 1 0 0", fetch_fault, n_req - r0, imem_req_valid);
    end
    rd_v = 1'b1; rd_t = 32'h300;
    step(); step();
    checks++;
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %0b exp 0", fetch_fault); end
    wait_pop(32'h300);
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    rdy = 1'b1; irdy = 1'b1; lat = 1; lat_rand = 0;
    step();
    rd_v = 1'b1; rd_t = 32'hFFFF_FFF8;
    step();
    wait_pop(32'hFFFF_FFF8);
    wait_pop(32'hFFFF_FFFC);
    wait_pop(32'h0000_0000);
    drain();
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rdy  = ($urandom_range(3, 0) != 0);
      irdy = ($urandom_range(3, 0) != 0);
      if ($urandom_range(19, 0) == 0) begin
        rd_v = 1'b1;
        rd_t = $urandom & 32'h0000_0FFC;
        if ($urandom_range(7, 0) == 0) rd_t[1:0] = 2'b10;
      end
      step();
    end
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    lat_rand = 1;
    rand_cycles(300);
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset_mid_burst");
    do_reset();
    p0 = n_pop;
    rand_cycles(200);
    rd_v = 1'b1; rd_t = 32'h40;
    step();
    drain();
    checks++;
    if (n_pop == p0) begin errors++; $display("FAIL random_progress pops %0d exp >0", n_pop - p0); end
    lat_rand = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d exp finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;
    rdy = 1'b0; irdy = 1'b0; rd_v = 1'b0; rd_t = '0; lat = 1; lat_rand = 0;
    model_pc = RV; model_fault = 1'b0; last_due = 0; prev_stall = 1'b0;
    prev_addr = '0; last_pop_pc = '0; last_pop_ins = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_fault();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
